sna_response_transmitter: RTL

//  Response-flow half of the SNA bridge: accepts AXI4-Lite B and R responses from the slave and

---
 rtl/sna_response_transmitter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sna_response_transmitter.sv
// Response path of the SNA bridge: turns AXI4-Lite B/R responses into NoC flits
// addressed to the requester whose return tag was queued when the request issued.
module sna_response_transmitter #(
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 4,
   parameter int TAG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_tag_push,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              rd_tag_push,
   input  logic [TAG_W-1:0]  rd_tag,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_type,
   output logic [TAG_W-1:0]  out_dest,
   output logic              out_valid,
   input  logic              out_on_off,
   output logic              tag_overflow
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] TYPE_HEAD     = 2'b00;
   localparam logic [1:0] TYPE_TAIL     = 2'b10;
   localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

   typedef enum logic [1:0] {IDLE, WR_SEND, RD_HEAD, RD_TAIL} state_t;

   // Channel index 0 = write (B), 1 = read (R)
   logic [1:0]            fifo_push;
   logic [1:0]            fifo_pop;
   logic [1:0]            fifo_nempty;
   logic [1:0]            fifo_drop;
   logic [1:0][TAG_W-1:0] fifo_push_tag;
   logic [1:0][TAG_W-1:0] fifo_head;

   assign fifo_push     = {rd_tag_push, wr_tag_push};
   assign fifo_push_tag = {rd_tag, wr_tag};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_tag_fifo
         logic [TAG_W-1:0] mem_q [TAG_DEPTH];
         logic [TAG_W-1:0] mem_d [TAG_DEPTH];
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
         logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
         logic [CNT_W-1:0] count_q, count_d;
         logic             full;
         logic             do_push;

         // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then
         always_comb begin
            full     = (count_q == CNT_W'(TAG_DEPTH));
            do_push  = fifo_push[gi] & (~full | fifo_pop[gi]);
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (do_push) begin
               mem_d[wr_ptr_q] = fifo_push_tag[gi];
               wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (fifo_pop[gi]) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(fifo_pop[gi]);
         end

         always_ff @(posedge clk) begin
            mem_q <= mem_d;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               count_q  <= count_d;
            end
         end

         assign fifo_nempty[gi] = (count_q != '0);
         assign fifo_head[gi]   = mem_q[rd_ptr_q];
         assign fifo_drop[gi]   = fifo_push[gi] & full & ~fifo_pop[gi];
      end
   endgenerate

   state_t            state_q, state_d;
   logic              favour_rd_q, favour_rd_d;
   logic [1:0]        resp_q, resp_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        out_type_q, out_type_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [TAG_W-1:0]  out_dest_q, out_dest_d;
   logic              overflow_q, overflow_d;
   logic              cand_w, cand_r;
   logic              grant_w, grant_r;

   always_comb begin
      state_d     = state_q;
      favour_rd_d = favour_rd_q;
      resp_d      = resp_q;
      data_d      = data_q;
      tag_d       = tag_q;
      out_valid_d = 1'b0;
      out_type_d  = out_type_q;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;
      overflow_d  = overflow_q | (|fifo_drop);
      fifo_pop    = 2'b00;
      bready      = 1'b0;
      rready      = 1'b0;

      // A channel only competes once its return tag is known; contention flips the favour
      cand_w  = bvalid & fifo_nempty[0];
      cand_r  = rvalid & fifo_nempty[1];
      grant_w = cand_w & (~cand_r | ~favour_rd_q);
      grant_r = cand_r & ~grant_w;

      case (state_q)
         IDLE: begin
            if (!rst) begin
               if (grant_w) begin
                  bready      = 1'b1;
                  fifo_pop[0] = 1'b1;
                  resp_d      = bresp;
                  tag_d       = fifo_head[0];
                  state_d     = WR_SEND;
                  if (cand_r) begin
                     favour_rd_d = 1'b1;
                  end
               end else if (grant_r) begin
                  rready      = 1'b1;
                  fifo_pop[1] = 1'b1;
                  resp_d      = rresp;
                  data_d      = rdata;
                  tag_d       = fifo_head[1];
                  state_d     = RD_HEAD;
                  if (cand_w) begin
                     favour_rd_d = 1'b0;
                  end
               end
            end
         end
         WR_SEND: begin
            if (out_on_off) begin
               out_valid_d = 1'b1;
               out_type_d  = TYPE_HEADTAIL;
               out_data_d  = {{(DATA_W-3){1'b0}}, 1'b0, resp_q};
               out_dest_d  = tag_q;
               state_d     = IDLE;
            end
         end
         RD_HEAD: begin
            if (out_on_off) begin
               out_valid_d = 1'b1;
               out_type_d  = TYPE_HEAD;
               out_data_d  = {{(DATA_W-3){1'b0}}, 1'b1, resp_q};
               out_dest_d  = tag_q;
               state_d     = RD_TAIL;
            end
         end
         RD_TAIL: begin
            if (out_on_off) begin
               out_valid_d = 1'b1;
               out_type_d  = TYPE_TAIL;
               out_data_d  = data_q;
               out_dest_d  = tag_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         favour_rd_q <= 1'b0;
         resp_q      <= '0;
         data_q      <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         out_type_q  <= '0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         favour_rd_q <= favour_rd_d;
         resp_q      <= resp_d;
         data_q      <= data_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         out_type_q  <= out_type_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_type     = out_type_q;
   assign out_data     = out_data_q;
   assign out_dest     = out_dest_q;
   assign tag_overflow = overflow_q;

endmodule
